// File: rtl/multi_timer.sv
// multi_timer: free-running 64-bit tick counter (utime) with CHANNELS
// compare channels, APB register access and an optional watchdog.
//
// Optional feature macro: MULTI_TIMER_WATCHDOG_EN (compiles the watchdog in).
//
// Ports:
//   clk, reset          sole clock; asynchronous active-high reset
//   apb_PADDR[7:0]      byte address, bits [1:0] ignored
//   apb_PSEL/PENABLE/PWRITE, apb_PWDATA[31:0]   APB request
//   apb_PRDATA[31:0]    combinational read data, apb_PREADY tied high
//   utime[63:0]         current tick count
//   irq[CHANNELS-1:0]   per-channel interrupt (PENDING delayed one register)
//   wdt_reset           watchdog reset request (16-cycle pulse)
module multi_timer #(
    parameter int CLK_FREQ  = 60_000_000,
    parameter int TICK_FREQ = 1_000_000,
    parameter int CHANNELS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          apb_PADDR,
    input  logic                apb_PSEL,
    input  logic                apb_PENABLE,
    input  logic                apb_PWRITE,
    input  logic [31:0]         apb_PWDATA,
    output logic [31:0]         apb_PRDATA,
    output logic                apb_PREADY,
    output logic [63:0]         utime,
    output logic [CHANNELS-1:0] irq,
    output logic                wdt_reset
);

    localparam int DIV = CLK_FREQ / TICK_FREQ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic [PW-1:0]       r_presc;
    logic [63:0]         r_utime;
    logic [31:0]         r_shadow;
    logic [31:0]         r_lo_buf;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_enable;
    logic [CHANNELS-1:0] r_irq;
    logic [63:0]         r_cmp    [CHANNELS];
    logic [31:0]         r_period [CHANNELS];

    logic                w_wr;
    logic                w_rd;
    logic                w_tick;
    logic [5:0]          w_word;
    logic [3:0]          w_ch_idx;
    logic [1:0]          w_ch_reg;
    logic                w_ch_valid;
    logic                w_we_lo;
    logic                w_we_hi;
    logic                w_we_pend;
    logic                w_we_en;
    logic [CHANNELS-1:0] w_we_cmp_lo;
    logic [CHANNELS-1:0] w_we_cmp_hi;
    logic [CHANNELS-1:0] w_we_period;
    logic [CHANNELS-1:0] w_match;
    logic [CHANNELS-1:0] w_pend_nxt;
    logic [CHANNELS-1:0] w_en_nxt;
    logic [31:0]         w_wdt_rdata;
    logic                w_unused_addr;

    assign w_wr          = apb_PSEL & apb_PENABLE & apb_PWRITE;
    assign w_rd          = apb_PSEL & apb_PENABLE & ~apb_PWRITE;
    assign w_word        = apb_PADDR[7:2];
    // Channel window starts at 0x40; addresses below it wrap to idx >= 12.
    assign w_ch_idx      = apb_PADDR[7:4] - 4'd4;
    assign w_ch_reg      = apb_PADDR[3:2];
    assign w_ch_valid    = ({28'd0, w_ch_idx} < 32'(CHANNELS));
    assign w_unused_addr = ^apb_PADDR[1:0];

    assign w_we_lo   = w_wr & (w_word == 6'd0);
    assign w_we_hi   = w_wr & (w_word == 6'd1);
    assign w_we_pend = w_wr & (w_word == 6'd2);
    assign w_we_en   = w_wr & (w_word == 6'd3);

    assign w_tick = (r_presc == PRESC_MAX);

    always_comb begin
        w_we_cmp_lo = '0;
        w_we_cmp_hi = '0;
        w_we_period = '0;
        w_match     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_we_cmp_lo[i] = w_wr & w_ch_valid & (w_ch_idx == 4'(i)) & (w_ch_reg == 2'd0);
            w_we_cmp_hi[i] = w_wr & w_ch_valid & (w_ch_idx == 4'(i)) & (w_ch_reg == 2'd1);
            w_we_period[i] = w_wr & w_ch_valid & (w_ch_idx == 4'(i)) & (w_ch_reg == 2'd2);
            w_match[i]     = r_enable[i] & (r_utime >= r_cmp[i]);
        end
    end

    // New match beats a same-cycle W1C; CPU ENABLE write beats one-shot clear.
    always_comb begin
        w_pend_nxt = (r_pending & ~(w_we_pend ? apb_PWDATA[CHANNELS-1:0] : '0)) | w_match;
        w_en_nxt   = r_enable;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_match[i] && (r_period[i] == 32'd0)) begin
                w_en_nxt[i] = 1'b0;
            end
        end
        if (w_we_en) begin
            w_en_nxt = apb_PWDATA[CHANNELS-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc   <= '0;
            r_utime   <= '0;
            r_shadow  <= '0;
            r_lo_buf  <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_irq     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cmp[i]    <= '1;
                r_period[i] <= '0;
            end
        end else begin
            if (w_we_hi) begin
                r_utime <= {apb_PWDATA, r_lo_buf};
                r_presc <= '0;
            end else if (w_tick) begin
                r_utime <= r_utime + 64'd1;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            if (w_we_lo) begin
                r_lo_buf <= apb_PWDATA;
            end
            if (w_rd && (w_word == 6'd0)) begin
                r_shadow <= r_utime[63:32];
            end
            r_pending <= w_pend_nxt;
            r_enable  <= w_en_nxt;
            r_irq     <= r_pending;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_we_cmp_lo[i]) begin
                    r_cmp[i][31:0] <= apb_PWDATA;
                end else if (w_we_cmp_hi[i]) begin
                    r_cmp[i][63:32] <= apb_PWDATA;
                end else if (w_match[i] && (r_period[i] != 32'd0)) begin
                    r_cmp[i] <= r_cmp[i] + {32'd0, r_period[i]};
                end
                if (w_we_period[i]) begin
                    r_period[i] <= apb_PWDATA;
                end
            end
        end
    end

`ifdef MULTI_TIMER_WATCHDOG_EN
    logic [31:0] r_wdt_cnt;
    logic        r_wdt_armed;
    logic [4:0]  r_wdt_pulse;
    logic        w_we_wdt;

    assign w_we_wdt = w_wr & (w_word == 6'd4);

    // Expiry disarms immediately; the 16-cycle pulse then runs on its own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdt_cnt   <= '0;
            r_wdt_armed <= 1'b0;
            r_wdt_pulse <= '0;
        end else begin
            if (r_wdt_pulse != 5'd0) begin
                r_wdt_pulse <= r_wdt_pulse - 5'd1;
            end
            if (w_we_wdt) begin
                r_wdt_cnt   <= apb_PWDATA;
                r_wdt_armed <= (apb_PWDATA != 32'd0);
            end else if (r_wdt_armed) begin
                if (r_wdt_cnt == 32'd0) begin
                    r_wdt_armed <= 1'b0;
                    r_wdt_pulse <= 5'd16;
                end else if (w_tick) begin
                    r_wdt_cnt <= r_wdt_cnt - 32'd1;
                end
            end
        end
    end

    assign wdt_reset   = (r_wdt_pulse != 5'd0);
    assign w_wdt_rdata = r_wdt_cnt;
`else
    assign wdt_reset   = 1'b0;
    assign w_wdt_rdata = '0;
`endif

    always_comb begin
        apb_PRDATA = '0;
        case (w_word)
            6'd0: apb_PRDATA = r_utime[31:0];
            6'd1: apb_PRDATA = r_shadow;
            6'd2: apb_PRDATA[CHANNELS-1:0] = r_pending;
            6'd3: apb_PRDATA[CHANNELS-1:0] = r_enable;
            6'd4: apb_PRDATA = w_wdt_rdata;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (w_ch_valid && (w_ch_idx == 4'(i))) begin
                        case (w_ch_reg)
                            2'd0:    apb_PRDATA = r_cmp[i][31:0];
                            2'd1:    apb_PRDATA = r_cmp[i][63:32];
                            2'd2:    apb_PRDATA = r_period[i];
                            default: apb_PRDATA = '0;
                        endcase
                    end
                end
            end
        endcase
    end

    assign apb_PREADY = 1'b1;
    assign utime      = r_utime;
    assign irq        = r_irq;

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic [63:0] utime;
    logic [3:0]  irq;
    logic        wdt_reset;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] sb_q[$];

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [19];

    always #5 clk = ~clk;

    multi_timer #(
        .CLK_FREQ(60_000_000),
        .TICK_FREQ(1_000_000),
        .CHANNELS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .apb_PADDR(paddr),
        .apb_PSEL(psel),
        .apb_PENABLE(penable),
        .apb_PWRITE(pwrite),
        .apb_PWDATA(pwdata),
        .apb_PRDATA(prdata),
        .apb_PREADY(pready),
        .utime(utime),
        .irq(irq),
        .wdt_reset(wdt_reset)
    );

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d, e;
        sb_q.push_back(exp);
        apb_read(a, d);
        e = sb_q.pop_front();
        check(name, {32'd0, d}, {32'd0, e});
    endtask

    task automatic set_utime(input logic [31:0] lo, input logic [31:0] hi);
        apb_write(8'h00, lo);
        apb_write(8'h04, hi);
    endtask

    task automatic wait_utime(input string name, input logic [63:0] v, input int budget);
        int n = 0;
        while (utime !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, utime, v);
    endtask

    task automatic irq_latency(input string name, input int bitn, input int exp);
        int lat = 0;
        while (irq[bitn] !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check(name, 64'(lat), 64'(exp));
    endtask

    initial begin
        logic [31:0] lo, hi;
        bit seen;
        int k, h;

        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;

        repeat (3) @(negedge clk);
        check("utime_in_reset", utime, 64'd0);
        check("irq_in_reset", {60'd0, irq}, 64'd0);
        check("wdt_in_reset", {63'd0, wdt_reset}, 64'd0);
        check("pready", {63'd0, pready}, 64'd1);
        reset = 1'b0;

        repeat (179) @(posedge clk);
        #1 check("utime_before_3rd_tick", utime, 64'd2);
        @(posedge clk);
        #1 check("utime_after_180clk", utime, 64'd3);

        // register-level vectors
        tbl[0]  = '{1'b0, 8'h40, 32'h0,        32'hFFFF_FFFF};
        tbl[1]  = '{1'b0, 8'h44, 32'h0,        32'hFFFF_FFFF};
        tbl[2]  = '{1'b0, 8'h48, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 8'h08, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, 8'h0C, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 8'h10, 32'h0,        32'h0};
        tbl[6]  = '{1'b1, 8'h80, 32'h1234,     32'h0};
        tbl[7]  = '{1'b0, 8'h80, 32'h0,        32'h0};
        tbl[8]  = '{1'b1, 8'h68, 32'hABCD,     32'h0};
        tbl[9]  = '{1'b0, 8'h68, 32'h0,        32'hABCD};
        tbl[10] = '{1'b1, 8'h74, 32'h1234_5678, 32'h0};
        tbl[11] = '{1'b0, 8'h74, 32'h0,        32'h1234_5678};
        tbl[12] = '{1'b0, 8'h70, 32'h0,        32'hFFFF_FFFF};
        tbl[13] = '{1'b1, 8'h0C, 32'hF0,       32'h0};
        tbl[14] = '{1'b0, 8'h0C, 32'h0,        32'h0};
        tbl[15] = '{1'b0, 8'h7C, 32'h0,        32'h0};
        tbl[16] = '{1'b0, 8'h1C, 32'h0,        32'h0};
        tbl[17] = '{1'b1, 8'h77, 32'hFFFF_FFFF, 32'h0};
        tbl[18] = '{1'b0, 8'h74, 32'h0,        32'hFFFF_FFFF};
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
            else apb_read_chk($sformatf("vec%0d_addr%02h", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
        end

        // time load and carry into the high word
        set_utime(32'hFFFF_FFFF, 32'h0);
        check("utime_loaded", utime, 64'h0000_0000_FFFF_FFFF);
        repeat (59) @(posedge clk);
        #1 check("utime_before_carry", utime, 64'h0000_0000_FFFF_FFFF);
        @(posedge clk);
        #1 check("utime_carry", utime, 64'h0000_0001_0000_0000);

        // LO read just before the carry, HI read just after
        set_utime(32'hFFFF_FFFF, 32'h0);
        repeat (55) @(negedge clk);
        apb_read(8'h00, lo);
        apb_read(8'h04, hi);
        check("coherent_pair", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
        check("utime_after_pair", utime, 64'h0000_0001_0000_0000);

        // channel 1 periodic
        set_utime(32'd90, 32'h0);
        apb_write(8'h50, 32'd100);
        apb_write(8'h54, 32'd0);
        apb_write(8'h58, 32'd50);
        apb_write(8'h0C, 32'h2);
        wait_utime("ch1_reach_100", 64'd100, 1000);
        irq_latency("ch1_irq_latency", 1, 2);
        apb_read_chk("ch1_cmp_lo_150", 8'h50, 32'd150);
        apb_read_chk("ch1_cmp_hi_0", 8'h54, 32'd0);
        apb_read_chk("pending_ch1", 8'h08, 32'h2);
        apb_write(8'h08, 32'h2);
        apb_read_chk("pending_after_w1c", 8'h08, 32'h0);
        wait_utime("ch1_reach_150", 64'd150, 4000);
        irq_latency("ch1_refire_latency", 1, 2);
        apb_read_chk("ch1_cmp_lo_200", 8'h50, 32'd200);
        apb_write(8'h0C, 32'h0);
        apb_write(8'h08, 32'hF);

        // channel 0 one-shot
        set_utime(32'd5, 32'h0);
        apb_write(8'h40, 32'd10);
        apb_write(8'h44, 32'd0);
        apb_write(8'h48, 32'd0);
        apb_write(8'h0C, 32'h1);
        wait_utime("ch0_reach_10", 64'd10, 1000);
        repeat (3) @(negedge clk);
        apb_read_chk("oneshot_pending", 8'h08, 32'h1);
        apb_read_chk("oneshot_enable_cleared", 8'h0C, 32'h0);
        apb_write(8'h08, 32'h1);
        wait_utime("ch0_reach_12", 64'd12, 300);
        apb_read_chk("oneshot_no_refire", 8'h08, 32'h0);

        // W1C lands in the same cycle the match sets PENDING[0]
        apb_write(8'h40, 32'd20);
        apb_write(8'h0C, 32'h1);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'h08; pwdata = 32'h1;
        wait_utime("ch0_reach_20", 64'd20, 1000);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb_read_chk("set_beats_w1c", 8'h08, 32'h1);
        apb_read_chk("oneshot2_enable_cleared", 8'h0C, 32'h0);

`ifdef MULTI_TIMER_WATCHDOG_EN
        set_utime(32'd0, 32'd0);
        apb_write(8'h10, 32'd5);
        apb_read_chk("wdt_loaded", 8'h10, 32'd5);
        k = 0;
        while (!wdt_reset && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("wdt_fire_delay", 64'(k), 64'd295);
        h = 0;
        while (wdt_reset && h < 40) begin
            @(negedge clk);
            h++;
        end
        check("wdt_pulse_len", 64'(h), 64'd16);
        apb_read_chk("wdt_after_fire", 8'h10, 32'd0);

        apb_write(8'h10, 32'd5);
        seen = 1'b0;
        for (int r = 0; r < 6; r++) begin
            repeat (180) begin
                @(negedge clk);
                if (wdt_reset) seen = 1'b1;
            end
            apb_write(8'h10, 32'd5);
        end
        check("wdt_kicked_no_reset", {63'd0, seen}, 64'd0);
        apb_write(8'h10, 32'd0);
        repeat (400) begin
            @(negedge clk);
            if (wdt_reset) seen = 1'b1;
        end
        check("wdt_disarmed_no_reset", {63'd0, seen}, 64'd0);
`else
        apb_write(8'h10, 32'd7);
        apb_read_chk("wdt_absent_reads_0", 8'h10, 32'd0);
        seen = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (wdt_reset) seen = 1'b1;
        end
        check("wdt_absent_no_reset", {63'd0, seen}, 64'd0);
`endif

        // 64-bit wrap
        set_utime(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (60) @(posedge clk);
        #1 check("utime_wrap", utime, 64'd0);

        // all channels pending, then asynchronous reset mid-period
        set_utime(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        apb_write(8'h0C, 32'hF);
        repeat (5) @(negedge clk);
        check("irq_all", {60'd0, irq}, 64'hF);
        apb_read_chk("pending_all", 8'h08, 32'hF);
        #2 reset = 1'b1;
        #1;
        check("irq_async_reset", {60'd0, irq}, 64'd0);
        check("utime_async_reset", utime, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        apb_read_chk("ch1_cmp_lo_reset", 8'h50, 32'hFFFF_FFFF);
        apb_read_chk("ch1_cmp_hi_reset", 8'h54, 32'hFFFF_FFFF);
        apb_read_chk("ch0_cmp_lo_reset", 8'h40, 32'hFFFF_FFFF);
        apb_read_chk("pending_reset", 8'h08, 32'h0);
        apb_read_chk("enable_reset", 8'h0C, 32'h0);
        apb_read_chk("ch1_period_reset", 8'h58, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 60_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_FREQ, default 1_000_000, utime tick rate in Hz; CLK_FREQ/TICK_FREQ SHALL be an integer >= 2.
REQ-003 SHALL have parameter CHANNELS, default 4, number of compare channels, legal range 1..8.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 apb_PADDR  input  8  byte address; bits [1:0] ignored.
REQ-007 apb_PSEL, apb_PENABLE, apb_PWRITE  input  1 each  APB control.
REQ-008 apb_PWDATA  input  32  write data.
REQ-009 apb_PRDATA  output  32  read data.
REQ-010 apb_PREADY  output  1  constant 1.
REQ-011 utime  output  64  current tick count.
REQ-012 irq  output  CHANNELS  per-channel interrupt, registered.
REQ-013 wdt_reset  output  1  watchdog reset request (see Configuration).

Function
REQ-014 Prescaler SHALL count 0..CLK_FREQ/TICK_FREQ-1; on wrap to 0, utime SHALL increment by 1 (64-bit, wraps from all-ones to 0).
REQ-015 Access = PSEL&PENABLE; write = access&PWRITE; read = access&~PWRITE; PRDATA SHALL be combinational from PADDR; unmapped addresses read 0, writes ignored.
REQ-016 Map: 0x00 TIME_LO, 0x04 TIME_HI, 0x08 PENDING (W1C), 0x0C ENABLE, 0x10 WDT; channel i at 0x40+16*i: +0 CMP_LO, +4 CMP_HI, +8 PERIOD (32-bit). Channel addresses i >= CHANNELS are unmapped.
REQ-017 A read of TIME_LO SHALL return utime[31:0] and latch utime[63:32] into a shadow; a read of TIME_HI SHALL return the shadow.
REQ-018 A write to TIME_LO SHALL store into a low buffer only; a write to TIME_HI SHALL load utime with {PWDATA, buffer} and clear the prescaler in the same cycle; this load overrides the tick increment.
REQ-019 Match for channel i SHALL be ENABLE[i] & (utime >= CMP[i]), unsigned 64-bit, evaluated from registered values; PENDING[i] SHALL set the cycle after the match is true.
REQ-020 On match with PERIOD[i] != 0, CMP[i] SHALL advance by PERIOD[i] (64-bit add, wraps) in the same cycle PENDING[i] sets.
REQ-021 On match with PERIOD[i] == 0 (one-shot), ENABLE[i] SHALL clear in the same cycle PENDING[i] sets.
REQ-022 irq[i] SHALL equal PENDING[i] delayed by one register.
REQ-023 A W1C to PENDING in the same cycle as a new set for that bit: set SHALL win.
REQ-024 A CPU write to CMP or ENABLE in the same cycle as an auto-update: the CPU write SHALL win.

Reset
REQ-025 On reset: prescaler, utime, shadow, low buffer, PENDING, ENABLE, PERIOD = 0; CMP = all-ones; irq = 0; wdt_reset = 0; watchdog disarmed.
REQ-026 Reset SHALL take effect immediately and asynchronously; release is synchronous to clk.

Configuration
REQ-027 Macro MULTI_TIMER_WATCHDOG_EN SHALL compile the watchdog in.
REQ-028 With it: writing WDT with nonzero N SHALL arm and load a down-counter with N, decremented per utime tick; writing 0 SHALL disarm; on reaching 0 while armed, wdt_reset SHALL be high for exactly 16 clk cycles, then disarm; reading WDT returns the remaining count.
REQ-029 Without it: wdt_reset SHALL be constant 0, WDT reads 0, and writes to WDT are ignored.

Verification
REQ-030 Defaults, reset release: after 3 * 60 clk, utime == 3; utime == 0 and irq == 0 during reset.
REQ-031 Write TIME_LO=0xFFFFFFFF, TIME_HI=0 -> utime 0x00000000_FFFFFFFF; after 1 tick, utime == 0x1_00000000; TIME_LO read then TIME_HI read across the carry -> coherent pair.
REQ-032 Channel 1: CMP=100, PERIOD=50, ENABLE[1]=1 -> irq[1] rises 2 cycles after utime reaches 100; CMP reads 150; W1C then re-fires at utime 150.
REQ-033 Channel 0: one-shot CMP=10, PERIOD=0 -> single PENDING[0], ENABLE[0] reads 0; W1C in the same cycle as a set -> PENDING stays 1.
REQ-034 With MULTI_TIMER_WATCHDOG_EN, WDT=5 -> wdt_reset high for 16 clk after 5 ticks; rewriting WDT=5 every 3 ticks -> wdt_reset never asserts.
REQ-035 Assert reset mid-period with PENDING=0xF -> irq == 0 at once, CMP reads 0xFFFFFFFF both halves.
